// File: rtl/program_loader_if.sv
// Loader bus: start, byte stream (valid/ready), the CPU imem/dmem write ports and status.
// master = image source / observer, slave = program_loader.
interface program_loader_if;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [63:0] imem_addr;
  logic        imem_wen;
  logic [31:0] imem_wdata;
  logic [63:0] dmem_addr;
  logic        dmem_wen;
  logic [63:0] dmem_wdata;
  logic        cpu_enable;
  logic        busy;
  logic        error;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, imem_addr, imem_wen, imem_wdata,
    input  dmem_addr, dmem_wen, dmem_wdata, cpu_enable, busy, error
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, imem_addr, imem_wen, imem_wdata,
    output dmem_addr, dmem_wen, dmem_wdata, cpu_enable, busy, error
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: unpacks a little-endian image (N_I, N_D, words, dwords) into CPU imem/dmem writes,
// then raises cpu_enable. Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader #(
  parameter int unsigned IMEM_DEPTH = 512,
  parameter int unsigned DMEM_DEPTH = 1024,
  parameter logic [63:0] IMEM_BASE  = 64'd0,
  parameter logic [63:0] DMEM_BASE  = 64'd0
) (
  input  logic            clk,
  input  logic            srst,
  program_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_IMEM, S_DMEM, S_CHK, S_DONE, S_ERR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t PAYLOAD_END = S_CHK;
`else
  localparam state_t PAYLOAD_END = S_DONE;
`endif

  localparam logic [16:0] IMEM_LIM = 17'(IMEM_DEPTH);
  localparam logic [16:0] DMEM_LIM = 17'(DMEM_DEPTH);

  state_t      state, state_nxt;
  logic [2:0]  byte_cnt;
  logic [15:0] word_cnt;
  logic [15:0] n_i, n_d;
  logic [23:0] hdr_lo;
  logic [55:0] pack;
  logic        imem_wen_q, dmem_wen_q;
  logic [63:0] imem_addr_q, dmem_addr_q;
  logic [31:0] imem_wdata_q;
  logic [63:0] dmem_wdata_q;
  logic        cpu_enable_q, error_q;
  logic        in_ready_c, busy_c, xfer, restart;
  logic [15:0] hdr_n_i, hdr_n_d;
  logic        last_word, last_dword;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  // No byte is taken during a write cycle, which keeps the two write ports from ever colliding.
  assign busy_c     = (state == S_HDR) || (state == S_IMEM) || (state == S_DMEM) || (state == S_CHK);
  assign in_ready_c = busy_c && !imem_wen_q && !dmem_wen_q;
  assign xfer       = bus.in_valid && in_ready_c;
  assign restart    = bus.start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

  assign hdr_n_i    = hdr_lo[15:0];
  assign hdr_n_d    = {bus.in_data, hdr_lo[23:16]};
  assign last_word  = (word_cnt == n_i - 16'd1);
  assign last_dword = (word_cnt == n_d - 16'd1);

  always_ff @(posedge clk) begin
    if (srst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = S_HDR;
      end
      S_HDR: begin
        if (xfer && byte_cnt == 3'd3) begin
          if ({1'b0, hdr_n_i} > IMEM_LIM || {1'b0, hdr_n_d} > DMEM_LIM) state_nxt = S_ERR;
          else if (hdr_n_i != 16'd0)                                   state_nxt = S_IMEM;
          else if (hdr_n_d != 16'd0)                                   state_nxt = S_DMEM;
          else                                                          state_nxt = PAYLOAD_END;
        end
      end
      S_IMEM: begin
        if (xfer && byte_cnt == 3'd3 && last_word)
          state_nxt = (n_d != 16'd0) ? S_DMEM : PAYLOAD_END;
      end
      S_DMEM: begin
        if (xfer && byte_cnt == 3'd7 && last_dword) state_nxt = PAYLOAD_END;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) state_nxt = (bus.in_data == csum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: begin
        if (bus.start) state_nxt = S_HDR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bytes are shifted in from the top, so after the last byte the word is {in_data, earlier bytes}.
  always_ff @(posedge clk) begin
    if (srst) begin
      byte_cnt     <= 3'd0;
      word_cnt     <= 16'd0;
      n_i          <= 16'd0;
      n_d          <= 16'd0;
      hdr_lo       <= 24'd0;
      pack         <= 56'd0;
      imem_wen_q   <= 1'b0;
      dmem_wen_q   <= 1'b0;
      imem_addr_q  <= 64'd0;
      dmem_addr_q  <= 64'd0;
      imem_wdata_q <= 32'd0;
      dmem_wdata_q <= 64'd0;
      cpu_enable_q <= 1'b0;
      error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= 8'd0;
`endif
    end else begin
      imem_wen_q   <= 1'b0;
      dmem_wen_q   <= 1'b0;
      cpu_enable_q <= (state == S_DONE) && (state_nxt == S_DONE);
      error_q      <= (state_nxt == S_ERR);
      if (restart) begin
        byte_cnt <= 3'd0;
        word_cnt <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
        csum     <= 8'd0;
`endif
      end else if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
        csum <= csum ^ bus.in_data;
`endif
        case (state)
          S_HDR: begin
            hdr_lo <= {bus.in_data, hdr_lo[23:8]};
            if (byte_cnt == 3'd3) begin
              n_i      <= hdr_n_i;
              n_d      <= hdr_n_d;
              byte_cnt <= 3'd0;
              word_cnt <= 16'd0;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
          S_IMEM: begin
            pack <= {bus.in_data, pack[55:8]};
            if (byte_cnt == 3'd3) begin
              imem_wen_q   <= 1'b1;
              imem_addr_q  <= IMEM_BASE + {46'd0, word_cnt, 2'b00};
              imem_wdata_q <= {bus.in_data, pack[55:32]};
              byte_cnt     <= 3'd0;
              word_cnt     <= last_word ? 16'd0 : word_cnt + 16'd1;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
          S_DMEM: begin
            pack <= {bus.in_data, pack[55:8]};
            if (byte_cnt == 3'd7) begin
              dmem_wen_q   <= 1'b1;
              dmem_addr_q  <= DMEM_BASE + {45'd0, word_cnt, 3'b000};
              dmem_wdata_q <= {bus.in_data, pack};
              byte_cnt     <= 3'd0;
              word_cnt     <= last_dword ? 16'd0 : word_cnt + 16'd1;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.busy       = busy_c;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wen   = imem_wen_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_wen   = dmem_wen_q;
  assign bus.dmem_wdata = dmem_wdata_q;
  assign bus.cpu_enable = cpu_enable_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a table of images plus hand sequences for
// enable timing, error recovery, mid-load reset and (when enabled) the checksum byte.
module tb_program_loader;
  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  program_loader_if bus();
  program_loader dut (.clk(clk), .srst(srst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  logic [95:0]  imem_q[$];
  logic [127:0] dmem_q[$];

  typedef struct {
    string        name;
    logic [191:0] s;
    int           len;
    bit           toggle;
    bit           exp_err;
    int           n_i;
    int           n_d;
    logic [31:0]  iw0;
    logic [31:0]  iw1;
    logic [63:0]  dw0;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: records every write and checks port exclusivity and stalled input.
  always @(negedge clk) begin
    if (bus.imem_wen) imem_q.push_back({bus.imem_addr, bus.imem_wdata});
    if (bus.dmem_wen) dmem_q.push_back({bus.dmem_addr, bus.dmem_wdata});
    if (bus.imem_wen || bus.dmem_wen) begin
      check("in_ready_on_write", 64'(bus.in_ready), 64'd0);
      check("wen_exclusive", 64'(bus.imem_wen & bus.dmem_wen), 64'd0);
    end
  end

  function automatic logic [7:0] xsum(input logic [191:0] s, input int len);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < len; i++) x = x ^ s[8*i +: 8];
    return x;
  endfunction

  task automatic set_vec(input int idx, input string name, input logic [191:0] s, input int len,
                         input bit toggle, input bit exp_err, input int n_i, input int n_d,
                         input logic [31:0] iw0, input logic [31:0] iw1, input logic [63:0] dw0);
    vecs[idx].name = name;    vecs[idx].s = s;             vecs[idx].len = len;
    vecs[idx].toggle = toggle; vecs[idx].exp_err = exp_err;
    vecs[idx].n_i = n_i;      vecs[idx].n_d = n_d;
    vecs[idx].iw0 = iw0;      vecs[idx].iw1 = iw1;         vecs[idx].dw0 = dw0;
  endtask

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  // Presents the first cnt bytes of a len-byte stream (byte 0 in the top occupied byte).
  task automatic send(input logic [191:0] s, input int len, input int cnt, input bit toggle);
    int i = 0;
    int cyc = 0;
    bit gap = 1'b0;
    while (i < cnt && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (toggle && gap) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = s[8*(len-1-i) +: 8];
      end
      gap = !gap;
      #1;
      if (bus.in_valid && bus.in_ready) i++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("send_budget", 64'(i), 64'(cnt));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_imem_addr"},  bus.imem_addr, 64'd0);
    check({tag, "_imem_wen"},   64'(bus.imem_wen), 64'd0);
    check({tag, "_imem_wdata"}, 64'(bus.imem_wdata), 64'd0);
    check({tag, "_dmem_addr"},  bus.dmem_addr, 64'd0);
    check({tag, "_dmem_wen"},   64'(bus.dmem_wen), 64'd0);
    check({tag, "_dmem_wdata"}, bus.dmem_wdata, 64'd0);
    check({tag, "_cpu_enable"}, 64'(bus.cpu_enable), 64'd0);
    check({tag, "_busy"},       64'(bus.busy), 64'd0);
    check({tag, "_error"},      64'(bus.error), 64'd0);
    check({tag, "_in_ready"},   64'(bus.in_ready), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [191:0] s;
    int len;
    logic [7:0] x;
    logic [191:0] img1;

    img1 = 192'({8'h02, 8'h00, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00,
                 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08});
    set_vec(0, "img1",        img1, 20, 1'b0, 1'b0, 2, 1, 32'h00000013, 32'h00100093, 64'h0807060504030201);
    set_vec(1, "img1_toggle", img1, 20, 1'b1, 1'b0, 2, 1, 32'h00000013, 32'h00100093, 64'h0807060504030201);
    set_vec(2, "empty",       192'({8'h00, 8'h00, 8'h00, 8'h00}), 4, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0, 64'h0);
    set_vec(3, "ni_too_big",  192'({8'h01, 8'h02, 8'h00, 8'h00}), 4, 1'b0, 1'b1, 0, 0, 32'h0, 32'h0, 64'h0);
    set_vec(4, "one_word",    192'({8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}), 8,
            1'b0, 1'b0, 1, 0, 32'h12345678, 32'h0, 64'h0);
    set_vec(5, "nd_too_big",  192'({8'h00, 8'h00, 8'h01, 8'h04}), 4, 1'b0, 1'b1, 0, 0, 32'h0, 32'h0, 64'h0);

    srst = 1'b1; bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    srst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      imem_q.delete(); dmem_q.delete();
      s = vecs[v].s; len = vecs[v].len;
`ifdef LOADER_CHECKSUM_EN
      if (!vecs[v].exp_err) begin
        x = xsum(s, len);
        s = (s << 8) | {184'd0, x};
        len++;
      end
`endif
      pulse_start();
      send(s, len, len, vecs[v].toggle);
      repeat (4) @(negedge clk);
      check({vecs[v].name, "_cpu_enable"}, 64'(bus.cpu_enable), 64'(!vecs[v].exp_err));
      check({vecs[v].name, "_error"},      64'(bus.error), 64'(vecs[v].exp_err));
      check({vecs[v].name, "_busy"},       64'(bus.busy), 64'd0);
      check({vecs[v].name, "_imem_cnt"},   64'(imem_q.size()), 64'(vecs[v].n_i));
      check({vecs[v].name, "_dmem_cnt"},   64'(dmem_q.size()), 64'(vecs[v].n_d));
      for (int j = 0; j < imem_q.size() && j < 2; j++) begin
        check({vecs[v].name, "_imem_addr"}, imem_q[j][95:32], 64'(4 * j));
        check({vecs[v].name, "_imem_data"}, 64'(imem_q[j][31:0]), 64'((j == 0) ? vecs[v].iw0 : vecs[v].iw1));
      end
      if (dmem_q.size() > 0) begin
        check({vecs[v].name, "_dmem_addr"}, dmem_q[0][127:64], 64'd0);
        check({vecs[v].name, "_dmem_data"}, dmem_q[0][63:0], vecs[v].dw0);
      end
    end

    // Restart out of ERR: error drops the cycle after start, then a good image loads.
    pulse_start();
    check("restart_error_clear", 64'(bus.error), 64'd0);
    check("restart_busy", 64'(bus.busy), 64'd1);
    imem_q.delete(); dmem_q.delete();
    s = img1; len = 20;
`ifdef LOADER_CHECKSUM_EN
    s = (s << 8) | {184'd0, xsum(img1, 20)}; len = 21;
`endif
    send(s, len, len, 1'b0);
    repeat (4) @(negedge clk);
    check("recover_cpu_enable", 64'(bus.cpu_enable), 64'd1);
    check("recover_imem_cnt", 64'(imem_q.size()), 64'd2);
    check("recover_dmem_cnt", 64'(dmem_q.size()), 64'd1);

    // Empty image: cpu_enable rises exactly two cycles after the final accepted byte.
    pulse_start();
    check("done_restart_cpu_clear", 64'(bus.cpu_enable), 64'd0);
    s = 192'({8'h00, 8'h00, 8'h00, 8'h00}); len = 4;
`ifdef LOADER_CHECKSUM_EN
    s = s << 8; len = 5;
`endif
    send(s, len, len, 1'b0);
    check("empty_t1_cpu_enable", 64'(bus.cpu_enable), 64'd0);
    check("empty_t1_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("empty_t2_cpu_enable", 64'(bus.cpu_enable), 64'd1);

    // Reset after 6 payload bytes, then bytes without start must be refused.
    pulse_start();
    send(img1, 20, 10, 1'b0);
    srst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    srst = 1'b0;
    imem_q.delete(); dmem_q.delete();
    bus.in_valid = 1'b1; bus.in_data = 8'h02;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("no_start_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("no_start_writes", 64'(imem_q.size() + dmem_q.size()), 64'd0);
    check("no_start_busy", 64'(bus.busy), 64'd0);

`ifdef LOADER_CHECKSUM_EN
    // Corrupted checksum: writes stand, but the CPU stays disabled.
    imem_q.delete(); dmem_q.delete();
    pulse_start();
    s = (img1 << 8) | {184'd0, xsum(img1, 20) ^ 8'h01};
    send(s, 21, 21, 1'b0);
    repeat (4) @(negedge clk);
    check("badsum_error", 64'(bus.error), 64'd1);
    check("badsum_cpu_enable", 64'(bus.cpu_enable), 64'd0);
    check("badsum_imem_cnt", 64'(imem_q.size()), 64'd2);
    check("badsum_dmem_cnt", 64'(dmem_q.size()), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
